// File: rtl/ui_event_arbiter.sv
// ui_event_arbiter: latches button/rotary pulses and serializes them by fixed priority into a FIFO
module ui_event_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_center,
    input  logic                     ev_north,
    input  logic                     ev_south,
    input  logic                     ev_east,
    input  logic                     ev_west,
    input  logic                     ev_cw,
    input  logic                     ev_ccw,
    input  logic                     evt_ready,
    input  logic                     clr_ovf,
    output logic                     evt_valid,
    output logic [2:0]               evt_code,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic [6:0]               pending,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [6:0]    ev;
    logic [6:0]    gnt;
    logic [6:0]    pending_next;
    logic [2:0]    gnt_code;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    mem [DEPTH];

    assign ev        = {ev_ccw, ev_cw, ev_west, ev_east, ev_south, ev_north, ev_center};
    assign full      = evt_count == CW'(DEPTH);
    assign evt_valid = evt_count != '0;
    assign evt_code  = evt_valid ? mem[rd_ptr] : 3'd0;
    assign pop       = evt_valid & evt_ready;

    // fixed-priority grant (cw > ccw > center > north > south > east > west), blocked on pre-pop full
    always_comb begin
        gnt_code     = full       ? 3'd0 :
                       pending[5] ? 3'd6 :
                       pending[6] ? 3'd7 :
                       pending[0] ? 3'd1 :
                       pending[1] ? 3'd2 :
                       pending[2] ? 3'd3 :
                       pending[3] ? 3'd4 :
                       pending[4] ? 3'd5 : 3'd0;
        push         = gnt_code != 3'd0;
        gnt          = push ? 7'd1 << (gnt_code - 3'd1) : 7'd0;
        pending_next = (pending & ~gnt) | ev;
        drop         = |(ev & pending & ~gnt);
    end

    // sticky pending latches and drop flag; a new drop beats clr_ovf
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= pending_next;
            ovf     <= drop | (ovf & ~clr_ovf);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            evt_count <= evt_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are masked by evt_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= gnt_code;
    end
endmodule

// File: tb/tb_ui_event_arbiter.sv
// tb_ui_event_arbiter: directed self-checking bench for ui_event_arbiter
module tb_ui_event_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ev_center = 0, ev_north = 0, ev_south = 0, ev_east = 0;
    logic       ev_west = 0, ev_cw = 0, ev_ccw = 0;
    logic       evt_ready = 0, clr_ovf = 0;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [2:0] evt_count;
    logic [6:0] pending;
    logic       ovf;
    int         n_cmp = 0;
    int         n_err = 0;

    ui_event_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ev_center(ev_center), .ev_north(ev_north), .ev_south(ev_south),
        .ev_east(ev_east), .ev_west(ev_west), .ev_cw(ev_cw), .ev_ccw(ev_ccw),
        .evt_ready(evt_ready), .clr_ovf(clr_ovf),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_count(evt_count),
        .pending(pending), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic state(input string tag, input logic v, input logic [2:0] c,
                         input logic [2:0] n, input logic [6:0] p, input logic o);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
        chk({tag, ".code"}, 32'(evt_code), 32'(c));
        chk({tag, ".count"}, 32'(evt_count), 32'(n));
        chk({tag, ".pending"}, 32'(pending), 32'(p));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
    endtask

    initial begin
        #1;
        state("reset", 0, 0, 0, 7'b0000000, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        state("idle", 0, 0, 0, 7'b0000000, 0);

        // single pulse, two-edge latency
        ev_north = 1; tick(); ev_north = 0;
        state("single.e0", 0, 0, 0, 7'b0000010, 0);
        tick();
        state("single.e1", 1, 2, 1, 7'b0000000, 0);
        evt_ready = 1; tick(); evt_ready = 0;
        state("single.pop", 0, 0, 0, 7'b0000000, 0);

        // simultaneous pulses enter in priority order
        ev_west = 1; ev_center = 1; ev_cw = 1; tick();
        ev_west = 0; ev_center = 0; ev_cw = 0;
        state("simul.e0", 0, 0, 0, 7'b0110001, 0);
        tick(); state("simul.e1", 1, 6, 1, 7'b0010001, 0);
        tick(); state("simul.e2", 1, 6, 2, 7'b0010000, 0);
        tick(); state("simul.e3", 1, 6, 3, 7'b0000000, 0);
        evt_ready = 1;
        tick(); state("simul.d1", 1, 1, 2, 7'b0000000, 0);
        tick(); state("simul.d2", 1, 5, 1, 7'b0000000, 0);
        tick(); state("simul.d3", 0, 0, 0, 7'b0000000, 0);
        evt_ready = 0;

        // fill to DEPTH with one event left pending
        ev_north = 1; tick(); ev_north = 0;
        ev_south = 1; tick(); ev_south = 0;
        ev_east = 1; tick(); ev_east = 0;
        ev_west = 1; tick(); ev_west = 0;
        ev_center = 1; tick(); ev_center = 0;
        state("full.a", 1, 2, 4, 7'b0000001, 0);
        tick();
        state("full.b", 1, 2, 4, 7'b0000001, 0);
        evt_ready = 1; tick(); evt_ready = 0;
        state("full.pop", 1, 3, 3, 7'b0000001, 0);
        tick();
        state("full.refill", 1, 3, 4, 7'b0000000, 0);

        // overflow and clear
        ev_center = 1; tick(); ev_center = 0;
        state("ovf.hold", 1, 3, 4, 7'b0000001, 0);
        ev_center = 1; tick(); ev_center = 0;
        state("ovf.drop", 1, 3, 4, 7'b0000001, 1);
        clr_ovf = 1; tick(); clr_ovf = 0;
        chk("ovf.clr", 32'(ovf), 32'd0);
        clr_ovf = 1; ev_center = 1; tick(); clr_ovf = 0; ev_center = 0;
        chk("ovf.set_wins", 32'(ovf), 32'd1);
        clr_ovf = 1; tick(); clr_ovf = 0;
        chk("ovf.clr2", 32'(ovf), 32'd0);

        // drain: [S,E,W,C] with C pending
        evt_ready = 1;
        tick();
        tick(); state("drain.t2", 1, 5, 3, 7'b0000000, 0);
        tick(); tick(); tick();
        state("drain.end", 0, 0, 0, 7'b0000000, 0);
        evt_ready = 0;

        // concurrent push and pop at two entries
        ev_north = 1; ev_south = 1; tick(); ev_north = 0; ev_south = 0;
        tick(); tick();
        state("pp.two", 1, 2, 2, 7'b0000000, 0);
        ev_east = 1; tick(); ev_east = 0;
        evt_ready = 1; tick(); evt_ready = 0;
        state("pp.same", 1, 3, 2, 7'b0000000, 0);

        // pulse coinciding with its own grant
        ev_west = 1; tick();
        tick(); ev_west = 0;
        state("self.grant", 1, 3, 3, 7'b0010000, 0);
        tick();
        state("self.next", 1, 3, 4, 7'b0000000, 0);
        evt_ready = 1;
        tick(); chk("order.1", 32'(evt_code), 32'd4);
        tick(); chk("order.2", 32'(evt_code), 32'd5);
        tick(); chk("order.3", 32'(evt_code), 32'd5);
        tick(); chk("order.empty", 32'(evt_valid), 32'd0);
        evt_ready = 0;

        // three entries, two pending, ovf set, then asynchronous reset
        ev_north = 1; ev_south = 1; ev_east = 1; ev_west = 1; tick();
        ev_north = 0; ev_south = 0; ev_east = 0;
        tick(); ev_west = 0;
        tick();
        ev_center = 1; tick(); ev_center = 0;
        state("prereset", 1, 2, 3, 7'b0010001, 1);
        #2 rst = 1'b0;
        #1;
        state("async.rst", 0, 0, 0, 7'b0000000, 0);
        #1 rst = 1'b1;
        ev_east = 1; ev_south = 1; tick(); ev_east = 0; ev_south = 0;
        state("post.e0", 0, 0, 0, 7'b0001100, 0);
        tick(); state("post.e1", 1, 3, 1, 7'b0001000, 0);
        tick(); state("post.e2", 1, 3, 2, 7'b0000000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
